// File: rtl/rv32im_decode_pipe.sv
// RV32I/M decode stage: valid/ready skid-free pipe register plus a speculative
// circular return-address stack that predicts JALR return targets.
module rv32im_decode_pipe #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned ILEN      = 32,
   parameter int unsigned REG_BITS  = 5,
   parameter int unsigned RAS_DEPTH = 4,
   parameter bit          ENABLE_M  = 1'b1
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       flush_i,
   input  logic                       ras_clear_i,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  logic [ILEN-1:0]            instruction_i,
   input  logic [XLEN-1:0]            pc_i,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [REG_BITS-1:0]        rs1_addr_o,
   output logic [REG_BITS-1:0]        rs2_addr_o,
   output logic [REG_BITS-1:0]        rd_addr_o,
   output logic [XLEN-1:0]            immediate_o,
   output logic                       immediate_valid_o,
   output logic [3:0]                 alu_operation_o,
   output logic [2:0]                 word_size_o,
   output logic [2:0]                 stage4_path_o,
   output logic                       memory_write_o,
   output logic                       branch_o,
   output logic                       jal_o,
   output logic                       jalr_o,
   output logic                       mret_o,
   output logic [2:0]                 branch_condition_o,
   output logic [XLEN-1:0]            jal_target_o,
   output logic [XLEN-1:0]            link_data_o,
   output logic                       ras_predict_valid_o,
   output logic [XLEN-1:0]            ras_predict_o,
   output logic [$clog2(RAS_DEPTH):0] ras_count_o,
   output logic                       illegal_o
);

   localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   localparam logic [4:0] OP_LOAD   = 5'b00000;
   localparam logic [4:0] OP_FENCE  = 5'b00011;
   localparam logic [4:0] OP_IMM    = 5'b00100;
   localparam logic [4:0] OP_AUIPC  = 5'b00101;
   localparam logic [4:0] OP_STORE  = 5'b01000;
   localparam logic [4:0] OP_OP     = 5'b01100;
   localparam logic [4:0] OP_LUI    = 5'b01101;
   localparam logic [4:0] OP_BRANCH = 5'b11000;
   localparam logic [4:0] OP_JALR   = 5'b11001;
   localparam logic [4:0] OP_JAL    = 5'b11011;
   localparam logic [4:0] OP_SYSTEM = 5'b11100;

   localparam logic [2:0] PATH_ALU = 3'b001;
   localparam logic [2:0] PATH_MEM = 3'b010;
   localparam logic [2:0] PATH_MUL = 3'b100;

   localparam logic [31:0] MRET_WORD = 32'h3020_0073;

   typedef struct packed {
      logic [REG_BITS-1:0] rs1;
      logic [REG_BITS-1:0] rs2;
      logic [REG_BITS-1:0] rd;
      logic [XLEN-1:0]     imm;
      logic                imm_valid;
      logic [3:0]          alu_op;
      logic [2:0]          word_size;
      logic [2:0]          path;
      logic                mem_write;
      logic                branch;
      logic                jal;
      logic                jalr;
      logic                mret;
      logic [2:0]          br_cond;
      logic [XLEN-1:0]     jal_target;
      logic [XLEN-1:0]     link;
      logic                pred_valid;
      logic [XLEN-1:0]     pred;
      logic                illegal;
   } dec_t;

   logic [31:0]        ins;
   logic [4:0]         opcode;
   logic [2:0]         f3;
   logic [4:0]         rd_f;
   logic [4:0]         rs1_f;
   logic [4:0]         rs2_f;
   logic signed [31:0] imm_i;
   logic signed [31:0] imm_s;
   logic signed [31:0] imm_b;
   logic signed [31:0] imm_u;
   logic signed [31:0] imm_j;
   logic [XLEN-1:0]    link_c;
   logic               rd_link;
   logic               rs1_link;

   dec_t               d;
   dec_t               q;
   logic               legal;
   logic               ras_push;
   logic               ras_pop;
   logic               accept;
   logic               acc_ok;

   logic [XLEN-1:0]    ras_mem [RAS_DEPTH];
   logic [PTR_W-1:0]   ras_ptr;
   logic [PTR_W-1:0]   top_idx;
   logic [CNT_W-1:0]   ras_cnt;

   assign ins      = instruction_i[31:0];
   assign opcode   = ins[6:2];
   assign f3       = ins[14:12];
   assign rd_f     = ins[11:7];
   assign rs1_f    = ins[19:15];
   assign rs2_f    = ins[24:20];
   assign imm_i    = {{20{ins[31]}}, ins[31:20]};
   assign imm_s    = {{20{ins[31]}}, ins[31:25], ins[11:7]};
   assign imm_b    = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
   assign imm_u    = {ins[31:12], 12'b0};
   assign imm_j    = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
   assign link_c   = pc_i + XLEN'(4);
   assign rd_link  = (rd_f == 5'd1) || (rd_f == 5'd5);
   assign rs1_link = (rs1_f == 5'd1) || (rs1_f == 5'd5);
   assign top_idx  = ras_ptr - PTR_W'(1);

   assign in_ready_o = ~out_valid_o | out_ready_i;
   assign accept     = in_valid_i & in_ready_o;
   assign acc_ok     = accept & ~flush_i;

   // Field decode, illegal squash to NOP, RAS action and prediction lookup.
   always_comb begin
      d        = '0;
      d.path   = PATH_ALU;
      legal    = 1'b1;
      ras_push = 1'b0;
      ras_pop  = 1'b0;
      case (opcode)
         OP_LUI: begin
            d.rd        = REG_BITS'(rd_f);
            d.imm       = XLEN'(imm_u);
            d.imm_valid = 1'b1;
         end
         OP_AUIPC: begin
            d.rd        = REG_BITS'(rd_f);
            d.imm       = pc_i + XLEN'(imm_u);
            d.imm_valid = 1'b1;
         end
         OP_JAL: begin
            d.rd         = REG_BITS'(rd_f);
            d.imm        = XLEN'(imm_j);
            d.imm_valid  = 1'b1;
            d.jal        = 1'b1;
            d.jal_target = pc_i + XLEN'(imm_j);
            d.link       = link_c;
         end
         OP_JALR: begin
            d.rd        = REG_BITS'(rd_f);
            d.rs1       = REG_BITS'(rs1_f);
            d.imm       = XLEN'(imm_i);
            d.imm_valid = 1'b1;
            d.jalr      = 1'b1;
            d.link      = link_c;
         end
         OP_BRANCH: begin
            d.rs1     = REG_BITS'(rs1_f);
            d.rs2     = REG_BITS'(rs2_f);
            d.imm     = XLEN'(imm_b);
            d.branch  = 1'b1;
            d.br_cond = f3;
         end
         OP_LOAD: begin
            d.rd        = REG_BITS'(rd_f);
            d.rs1       = REG_BITS'(rs1_f);
            d.imm       = XLEN'(imm_i);
            d.imm_valid = 1'b1;
            d.word_size = f3;
            d.path      = PATH_MEM;
         end
         OP_STORE: begin
            d.rs1       = REG_BITS'(rs1_f);
            d.rs2       = REG_BITS'(rs2_f);
            d.imm       = XLEN'(imm_s);
            d.imm_valid = 1'b1;
            d.mem_write = 1'b1;
            d.word_size = f3;
            d.path      = PATH_MEM;
         end
         OP_IMM: begin
            d.rd        = REG_BITS'(rd_f);
            d.rs1       = REG_BITS'(rs1_f);
            d.imm       = XLEN'(imm_i);
            d.imm_valid = 1'b1;
            // only shifts carry a funct7 qualifier; elsewhere bit 30 is immediate
            d.alu_op    = {(f3 == 3'b101) & ins[30], f3};
         end
         OP_OP: begin
            d.rd     = REG_BITS'(rd_f);
            d.rs1    = REG_BITS'(rs1_f);
            d.rs2    = REG_BITS'(rs2_f);
            d.alu_op = {ins[30], f3};
            if (ins[25]) begin
               if (ENABLE_M) d.path = PATH_MUL;
               else          legal  = 1'b0;
            end
         end
         OP_FENCE: ;
         OP_SYSTEM: d.mret = (ins == MRET_WORD);
         default: legal = 1'b0;
      endcase
      if (ins[1:0] != 2'b11) legal = 1'b0;
      if (!legal) begin
         d         = '0;
         d.path    = PATH_ALU;
         d.illegal = 1'b1;
      end
      if (d.jal) ras_push = rd_link;
      if (d.jalr) begin
         ras_push = rd_link;
         ras_pop  = rs1_link & ~(rd_link & (rd_f == rs1_f));
      end
      d.pred_valid = ras_pop & (ras_cnt != '0);
      d.pred       = d.pred_valid ? ras_mem[top_idx] : '0;
   end

   // Circular RAS; a push when full lands on the oldest slot.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ras_ptr <= '0;
         ras_cnt <= '0;
         for (int unsigned i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
      end else if (ras_clear_i) begin
         ras_ptr <= '0;
         ras_cnt <= '0;
      end else if (acc_ok) begin
         if (d.pred_valid && ras_push) begin
            ras_mem[top_idx] <= link_c;
         end else if (ras_push) begin
            ras_mem[ras_ptr] <= link_c;
            ras_ptr          <= ras_ptr + PTR_W'(1);
            ras_cnt          <= (ras_cnt == CNT_W'(RAS_DEPTH)) ? ras_cnt : ras_cnt + CNT_W'(1);
         end else if (d.pred_valid) begin
            ras_ptr <= top_idx;
            ras_cnt <= ras_cnt - CNT_W'(1);
         end
      end
   end

   // Output pipe register; a flushed accept is dropped entirely.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_valid_o <= 1'b0;
         q           <= '0;
      end else begin
         if (flush_i)          out_valid_o <= 1'b0;
         else if (accept)      out_valid_o <= 1'b1;
         else if (out_ready_i) out_valid_o <= 1'b0;
         if (acc_ok) q <= d;
      end
   end

   assign rs1_addr_o          = q.rs1;
   assign rs2_addr_o          = q.rs2;
   assign rd_addr_o           = q.rd;
   assign immediate_o         = q.imm;
   assign immediate_valid_o   = q.imm_valid;
   assign alu_operation_o     = q.alu_op;
   assign word_size_o         = q.word_size;
   assign stage4_path_o       = q.path;
   assign memory_write_o      = q.mem_write;
   assign branch_o            = q.branch;
   assign jal_o               = q.jal;
   assign jalr_o              = q.jalr;
   assign mret_o              = q.mret;
   assign branch_condition_o  = q.br_cond;
   assign jal_target_o        = q.jal_target;
   assign link_data_o         = q.link;
   assign ras_predict_valid_o = q.pred_valid;
   assign ras_predict_o       = q.pred;
   assign illegal_o           = q.illegal;
   assign ras_count_o         = ras_cnt;

endmodule

// File: tb/tb_rv32im_decode_pipe.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic against a queue-based decode/RAS reference model.
module tb_rv32im_decode_pipe;

   localparam int unsigned DEPTH = 4;
   localparam bit          EN_M  = 1'b1;

   logic        clk_i = 1'b0;
   logic        rst_ni, flush_i, ras_clear_i, in_valid_i, out_ready_i;
   logic [31:0] instruction_i, pc_i;
   logic        in_ready_o, out_valid_o;
   logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
   logic [31:0] immediate_o, jal_target_o, link_data_o, ras_predict_o;
   logic        immediate_valid_o, memory_write_o, branch_o, jal_o, jalr_o, mret_o;
   logic        ras_predict_valid_o, illegal_o;
   logic [3:0]  alu_operation_o;
   logic [2:0]  word_size_o, stage4_path_o, branch_condition_o, ras_count_o;

   rv32im_decode_pipe #(.XLEN(32), .ILEN(32), .REG_BITS(5), .RAS_DEPTH(DEPTH), .ENABLE_M(EN_M)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .ras_clear_i(ras_clear_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .instruction_i(instruction_i), .pc_i(pc_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o), .rd_addr_o(rd_addr_o),
      .immediate_o(immediate_o), .immediate_valid_o(immediate_valid_o),
      .alu_operation_o(alu_operation_o), .word_size_o(word_size_o), .stage4_path_o(stage4_path_o),
      .memory_write_o(memory_write_o), .branch_o(branch_o), .jal_o(jal_o), .jalr_o(jalr_o),
      .mret_o(mret_o), .branch_condition_o(branch_condition_o), .jal_target_o(jal_target_o),
      .link_data_o(link_data_o), .ras_predict_valid_o(ras_predict_valid_o),
      .ras_predict_o(ras_predict_o), .ras_count_o(ras_count_o), .illegal_o(illegal_o));

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] imm, jt, link, pred;
      logic        immv, mw, br, jal, jalr, mret, ill, pv;
      logic [3:0]  alu;
      logic [2:0]  ws, path, bc;
      bit          c_imm, c_immv, c_alu, c_ws, c_bc, c_jt, c_link, c_path;
   } exp_t;

   exp_t        m_out;
   bit          m_valid;
   logic [31:0] ras_q[$];
   int          n_pass = 0;
   int          n_checks = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
   endtask

   function automatic exp_t decode(input logic [31:0] ins, input logic [31:0] pc);
      exp_t               e;
      logic signed [31:0] s;
      logic [31:0]        ii, si, ui, ji;
      logic [2:0]         f3;
      bit                 ill;
      e   = '{default: '0};
      s   = ins;
      f3  = ins[14:12];
      ill = 1'b0;
      ii  = 32'(s >>> 20);
      si  = 32'((s >>> 25) <<< 5) | 32'(ins[11:7]);
      ui  = ins & 32'hFFFF_F000;
      ji  = 32'((s >>> 31) <<< 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
      e.path = 3'b001;
      e.c_path = 1'b1;
      case (ins[6:2])
         5'b01101: begin e.rd = ins[11:7]; e.imm = ui; e.immv = 1; e.c_imm = 1; e.c_immv = 1; end
         5'b00101: begin e.rd = ins[11:7]; e.imm = pc + ui; e.immv = 1; e.c_imm = 1; e.c_immv = 1; end
         5'b11011: begin
            e.rd = ins[11:7]; e.imm = ji; e.immv = 1; e.c_imm = 1; e.c_immv = 1;
            e.jal = 1; e.jt = pc + ji; e.c_jt = 1; e.link = pc + 4; e.c_link = 1;
         end
         5'b11001: begin
            e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.imm = ii; e.immv = 1; e.c_imm = 1; e.c_immv = 1;
            e.jalr = 1; e.link = pc + 4; e.c_link = 1;
         end
         5'b11000: begin
            e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.c_immv = 1;
            e.br = 1; e.bc = f3; e.c_bc = 1;
         end
         5'b00000: begin
            e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.imm = ii; e.immv = 1; e.c_imm = 1; e.c_immv = 1;
            e.ws = f3; e.c_ws = 1; e.path = 3'b010;
         end
         5'b01000: begin
            e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.imm = si; e.immv = 1; e.c_imm = 1; e.c_immv = 1;
            e.mw = 1; e.ws = f3; e.c_ws = 1; e.path = 3'b010;
         end
         5'b00100: begin
            e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.imm = ii; e.immv = 1; e.c_imm = 1; e.c_immv = 1;
            e.alu = {(f3 == 3'd5) ? ins[30] : 1'b0, f3}; e.c_alu = 1;
         end
         5'b01100: begin
            e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.c_immv = 1;
            e.alu = {ins[30], f3}; e.c_alu = 1;
            if (ins[25]) begin
               if (EN_M) e.path = 3'b100;
               else      ill = 1;
            end
         end
         5'b00011: ;
         5'b11100: e.mret = (ins == 32'h3020_0073);
         default:  ill = 1;
      endcase
      if (ins[1:0] != 2'b11) ill = 1;
      if (ill) begin
         e     = '{default: '0};
         e.ill = 1;
      end
      return e;
   endfunction

   task automatic model_reset();
      m_valid = 0;
      ras_q.delete();
      m_out = '{default: '0};
   endtask

   task automatic model_update(input bit acc);
      exp_t d;
      bit   rdl, rsl, push, pop;
      if (flush_i) begin
         m_valid = 0;
      end else if (acc) begin
         d    = decode(instruction_i, pc_i);
         rdl  = (d.rd == 5'd1) || (d.rd == 5'd5);
         rsl  = (d.rs1 == 5'd1) || (d.rs1 == 5'd5);
         push = (d.jal || d.jalr) && rdl;
         pop  = d.jalr && rsl && !(rdl && d.rd == d.rs1);
         if (pop && ras_q.size() > 0) begin
            d.pv   = 1;
            d.pred = ras_q[$];
         end
         if (!ras_clear_i) begin
            if (d.pv) void'(ras_q.pop_back());
            if (push) begin
               ras_q.push_back(pc_i + 32'd4);
               if (ras_q.size() > DEPTH) void'(ras_q.pop_front());
            end
         end
         m_out   = d;
         m_valid = 1;
      end else if (out_ready_i) begin
         m_valid = 0;
      end
      if (ras_clear_i) ras_q.delete();
   endtask

   task automatic compare();
      check("out_valid", 32'(out_valid_o), 32'(m_valid));
      check("ras_count", 32'(ras_count_o), 32'(ras_q.size()));
      if (m_valid) begin
         check("rs1", 32'(rs1_addr_o), 32'(m_out.rs1));
         check("rs2", 32'(rs2_addr_o), 32'(m_out.rs2));
         check("rd", 32'(rd_addr_o), 32'(m_out.rd));
         check("mem_write", 32'(memory_write_o), 32'(m_out.mw));
         check("branch", 32'(branch_o), 32'(m_out.br));
         check("jal", 32'(jal_o), 32'(m_out.jal));
         check("jalr", 32'(jalr_o), 32'(m_out.jalr));
         check("mret", 32'(mret_o), 32'(m_out.mret));
         check("illegal", 32'(illegal_o), 32'(m_out.ill));
         check("pred_valid", 32'(ras_predict_valid_o), 32'(m_out.pv));
         if (m_out.pv)     check("pred", ras_predict_o, m_out.pred);
         if (m_out.c_imm)  check("imm", immediate_o, m_out.imm);
         if (m_out.c_immv) check("imm_valid", 32'(immediate_valid_o), 32'(m_out.immv));
         if (m_out.c_alu)  check("alu_op", 32'(alu_operation_o), 32'(m_out.alu));
         if (m_out.c_ws)   check("word_size", 32'(word_size_o), 32'(m_out.ws));
         if (m_out.c_bc)   check("br_cond", 32'(branch_condition_o), 32'(m_out.bc));
         if (m_out.c_jt)   check("jal_target", jal_target_o, m_out.jt);
         if (m_out.c_link) check("link", link_data_o, m_out.link);
         if (m_out.c_path) check("path", 32'(stage4_path_o), 32'(m_out.path));
      end
   endtask

   // One clock: handshake check before the edge, model advance, output compare after.
   task automatic step();
      bit rdy;
      #1;
      rdy = !m_valid || out_ready_i;
      check("in_ready", 32'(in_ready_o), 32'(rdy));
      @(posedge clk_i);
      model_update(in_valid_i && rdy);
      #1;
      compare();
   endtask

   task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
      in_valid_i = 1; instruction_i = ins; pc_i = pc;
      out_ready_i = 1; flush_i = 0; ras_clear_i = 0;
      step();
      in_valid_i = 0;
   endtask

   function automatic logic [4:0] pick_reg();
      case ($urandom_range(0, 3))
         0:       return 5'd0;
         1:       return 5'd1;
         2:       return 5'd5;
         default: return 5'($urandom);
      endcase
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      int          k, b;
      w = $urandom;
      k = $urandom_range(0, 13);
      case (k)
         0:    w[6:0] = 7'h37;
         1:    w[6:0] = 7'h17;
         2, 3: begin w[6:0] = 7'h6F; w[11:7] = pick_reg(); end
         4, 5: begin w[6:0] = 7'h67; w[14:12] = 3'd0; w[11:7] = pick_reg(); w[19:15] = pick_reg(); end
         6: begin
            w[6:0] = 7'h63; b = $urandom_range(0, 5);
            w[14:12] = (b < 2) ? 3'(b) : 3'(b + 2);
         end
         7:  w[6:0] = 7'h03;
         8:  w[6:0] = 7'h23;
         9:  w[6:0] = 7'h13;
         10: begin
            w[6:0] = 7'h33; b = $urandom_range(0, 2);
            w[31:25] = (b == 0) ? 7'h00 : (b == 1) ? 7'h20 : 7'h01;
         end
         11: w = ($urandom_range(0, 1) != 0) ? 32'h3020_0073 : 32'h0000_0073;
         12: w[6:0] = 7'h0F;
         default: ;
      endcase
      return w;
   endfunction

   localparam logic [31:0] JAL_X1  = 32'h0080_00EF;
   localparam logic [31:0] RET     = 32'h0000_8067;
   localparam logic [31:0] AUIPC_5 = 32'h0000_1297;
   localparam logic [31:0] LUI_3   = 32'hABCD_E1B7;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_ni = 0; flush_i = 0; ras_clear_i = 0; in_valid_i = 0; out_ready_i = 0;
      instruction_i = '0; pc_i = '0;
      model_reset();
      repeat (2) @(posedge clk_i);
      #1;
      check("rst out_valid", 32'(out_valid_o), 32'd0);
      check("rst ras_count", 32'(ras_count_o), 32'd0);
      check("rst in_ready", 32'(in_ready_o), 32'd1);
      check("rst imm", immediate_o, 32'd0);
      @(negedge clk_i);
      rst_ni = 1;

      issue(JAL_X1, 32'h100);
      check("lit jal_target", jal_target_o, 32'h108);
      check("lit link", link_data_o, 32'h104);
      check("lit count push", 32'(ras_count_o), 32'd1);
      issue(RET, 32'h108);
      check("lit pred", ras_predict_o, 32'h104);
      check("lit pred_valid", 32'(ras_predict_valid_o), 32'd1);
      check("lit count pop", 32'(ras_count_o), 32'd0);
      issue(RET, 32'h10C);
      check("lit empty pred_valid", 32'(ras_predict_valid_o), 32'd0);
      check("lit empty count", 32'(ras_count_o), 32'd0);

      for (int i = 0; i < 5; i++) issue(JAL_X1, 32'(i * 16));
      check("lit full count", 32'(ras_count_o), 32'd4);
      for (int i = 0; i < 4; i++) begin
         issue(RET, 32'h800);
         check("lit wrap pred", ras_predict_o, 32'h44 - 32'(i * 16));
      end
      issue(RET, 32'h800);
      check("lit drained pred_valid", 32'(ras_predict_valid_o), 32'd0);

      issue(JAL_X1, 32'h500);
      in_valid_i = 1; instruction_i = JAL_X1; pc_i = 32'h600; flush_i = 1;
      step();
      check("lit flush valid", 32'(out_valid_o), 32'd0);
      check("lit flush count", 32'(ras_count_o), 32'd1);
      in_valid_i = 0; flush_i = 0; ras_clear_i = 1;
      step();
      check("lit clear count", 32'(ras_count_o), 32'd0);
      ras_clear_i = 0;

      issue(32'h0000_0000, 32'h700);
      check("lit illegal", 32'(illegal_o), 32'd1);
      check("lit illegal rd", 32'(rd_addr_o), 32'd0);
      check("lit illegal jal", 32'(jal_o), 32'd0);

      issue(AUIPC_5, 32'h200);
      check("lit auipc", immediate_o, 32'h1200);
      in_valid_i = 1; instruction_i = LUI_3; pc_i = 32'h300; out_ready_i = 0;
      repeat (3) begin
         step();
         check("lit bp frozen imm", immediate_o, 32'h1200);
         check("lit bp in_ready", 32'(in_ready_o), 32'd0);
      end
      out_ready_i = 1;
      step();
      check("lit bp new imm", immediate_o, 32'hABCD_E000);
      in_valid_i = 0;
      step();
      check("lit bp one beat", 32'(out_valid_o), 32'd0);

      issue(JAL_X1, 32'h900);
      rst_ni = 0;
      #1;
      check("lit midrst valid", 32'(out_valid_o), 32'd0);
      check("lit midrst count", 32'(ras_count_o), 32'd0);
      check("lit midrst in_ready", 32'(in_ready_o), 32'd1);
      check("lit midrst jal", 32'(jal_o), 32'd0);
      model_reset();
      @(negedge clk_i);
      rst_ni = 1;

      for (int c = 0; c < 3000; c++) begin
         in_valid_i    = ($urandom_range(0, 3) != 0);
         out_ready_i   = ($urandom_range(0, 3) != 0);
         flush_i       = ($urandom_range(0, 15) == 0);
         ras_clear_i   = ($urandom_range(0, 31) == 0);
         instruction_i = rand_instr();
         pc_i          = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
